div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
- Multi-cycle iterative divider and its sequencer for the 54-instruction multicycle MIPS core. Serves DIV and DIVU.
- The main controller FSM pulses start, then waits on done; it writes quotient to LO and remainder to HI.
- Holds a radix-2 restoring shift-subtract datapath, an iteration counter and a 5-state FSM.
- Supports abort from the CP0 exception path.

Parameters:
- WIDTH, 32, operand/result width; iteration counter is clog2(WIDTH)+1 bits.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a divide; sampled only in IDLE
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; latched with start
- dividend  input  WIDTH  rs operand; latched with start
- divisor  input  WIDTH  rt operand; latched with start
- abort  input  1  synchronous cancel from exception logic
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse; quotient/remainder valid
- quotient  output  WIDTH  LO result; held until next completion
- remainder  output  WIDTH  HI result; held until next completion
- div_zero  output  1  set on completion when divisor was 0; cleared on next accepted start

Behaviour:
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_zero=0, state=IDLE, counter=0.
- Priority: reset > abort > start.
- Cycle 0 is the IDLE cycle in which start=1 is sampled.
- IDLE:
  - start=1 latches operands and is_signed, clears div_zero, goes to PREP.
  - start=0 stays in IDLE.
- PREP (cycle 1):
  - Forms magnitudes: if is_signed and MSB set, negate; else pass through. Records quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend).
  - Clears the partial remainder, loads the shift register with |dividend|, counter=0.
  - If divisor==0, goes to DONE with quotient=all ones and remainder=raw dividend; div_zero=1, done in cycle 2.
  - Otherwise goes to ITER.
- ITER (cycles 2..WIDTH+1, exactly WIDTH cycles):
  - Each cycle: shift {rem,quo} left by 1; trial = rem_shifted - |divisor| on WIDTH+1 bits.
  - If trial is non-negative, rem = trial and quotient LSB = 1; else quotient LSB = 0.
  - Counter increments; after count reaches WIDTH-1, goes to FIX.
- FIX (cycle WIDTH+2): applies sign correction (negate quotient if quotient sign=1; negate remainder if remainder sign=1), registers outputs, goes to DONE.
- DONE (cycle WIDTH+3, i.e. cycle 35 for WIDTH=32): done=1 for this cycle only, busy=1, then unconditionally goes to IDLE. start in DONE is ignored.
- Overflow case: 0x80000000 / 0xFFFFFFFF signed gives quotient=0x80000000, remainder=0, with no special flag; this falls out of the unsigned-magnitude path.
- start while busy is ignored and has no effect on latched operands.
- abort in any non-IDLE state: next state is IDLE, no done pulse, quotient/remainder/div_zero keep their previous values. abort in IDLE has no effect.
- reset mid-operation returns all registers to reset values on the same edge.
- Outputs change only in FIX, in the div-by-zero PREP transition, or on reset.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in PREP, if divisor!=0 and |dividend| < |divisor| (unsigned compare), go directly to FIX with magnitude quotient=0 and magnitude remainder=|dividend|. Sign correction still applies. done occurs in cycle 3.
- Undefined: always performs the full WIDTH iterations; fixed latency, done in cycle WIDTH+3.

Test Plan:
- DIVU 100/7 (0x64, 0x7) -> quotient=0x0000000E, remainder=0x00000002, div_zero=0; busy high cycles 1..35; single done pulse in cycle 35.
- DIV 0xFFFFFFF9 / 0x00000002 (-7/2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Repeat as DIVU -> quotient=0x7FFFFFFC, remainder=0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0x00000000, done in cycle 35.
- DIVU 5/0 -> div_zero=1, quotient=0xFFFFFFFF, remainder=0x00000005, done in cycle 2; next start clears div_zero.
- Complete 100/7, then start 9/3 and assert abort in cycle 10 -> busy low in cycle 11, no done, outputs still 0x0E/0x02. start pulsed in cycle 5 of a running op -> ignored, result unchanged. reset in cycle 20 -> all outputs 0 next cycle.
- DIVU 3/10 -> quotient=0, remainder=3; done in cycle 3 with DIV_EARLY_OUT_EN defined, cycle 35 without.

Source files
------------

// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider with sequencer for DIV/DIVU (quotient -> LO, remainder -> HI).
// Optional DIV_EARLY_OUT_EN: skip the iterations when |dividend| < |divisor|.
module div_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dd_q, dd_d;
    logic [WIDTH-1:0]   dv_q, dv_d;
    logic               sgn_q, sgn_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvm_q, dvm_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               div_zero_q, div_zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   dd_mag, dv_mag;
    logic [WIDTH:0]     rem_sh, trial;

    // Operand magnitudes and the trial subtraction of one restoring step
    assign dd_mag = (sgn_q && dd_q[WIDTH-1]) ? -dd_q : dd_q;
    assign dv_mag = (sgn_q && dv_q[WIDTH-1]) ? -dv_q : dv_q;
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvm_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dd_q        <= '0;
            dv_q        <= '0;
            sgn_q       <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvm_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dd_q        <= dd_d;
            dv_q        <= dv_d;
            sgn_q       <= sgn_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvm_q       <= dvm_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dd_d        = dd_q;
        dv_d        = dv_q;
        sgn_d       = sgn_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvm_d       = dvm_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dd_d       = dividend;
                    dv_d       = divisor;
                    sgn_d      = is_signed;
                    div_zero_d = 1'b0;
                    state_d    = PREP;
                end
            end
            PREP: begin
                rem_d  = '0;
                quo_d  = dd_mag;
                dvm_d  = dv_mag;
                qneg_d = sgn_q & (dd_q[WIDTH-1] ^ dv_q[WIDTH-1]);
                rneg_d = sgn_q & dd_q[WIDTH-1];
                cnt_d  = '0;
                if (dv_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = dd_q;
                    div_zero_d  = 1'b1;
                    state_d     = DONE;
                end
`ifdef DIV_EARLY_OUT_EN
                else if (dd_mag < dv_mag) begin
                    quo_d   = '0;
                    rem_d   = dd_mag;
                    state_d = FIX;
                end
`endif
                else begin
                    state_d = ITER;
                end
            end
            ITER: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quotient_d  = qneg_q ? -quo_q : quo_q;
                remainder_d = rneg_q ? -rem_q : rem_q;
                state_d     = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort cancels any in-flight op and discards pending output updates
        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            quotient_d  = quotient_q;
            remainder_d = remainder_q;
            div_zero_d  = div_zero_q;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: expected results queued at issue, checked at the done pulse.
module tb_div_sequencer;

    localparam int unsigned W = 32;
`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_CYC = 3;
`else
    localparam int EARLY_CYC = 35;
`endif

    logic         clk = 1'b0;
    logic         reset, start, is_signed, abort;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, div_zero;
    logic [W-1:0] quotient, remainder;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    div_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive start for one cycle (cycle 0); leaves the bench in cycle 1
    task automatic issue(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic sg,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                         input int ecyc, input bit push);
        exp_t e;
        dividend  = dd;
        divisor   = dv;
        is_signed = sg;
        start     = 1'b1;
        if (push) begin
            e.q = eq; e.r = er; e.dz = edz; e.cyc = ecyc;
            sb.push_back(e);
        end
        tick();
        start = 1'b0;
        cyc   = 1;
    endtask

    // Wait (bounded) for done, then compare against the oldest queued expectation
    task automatic wait_done(input string tag);
        exp_t e;
        int   busy_bad = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy !== 1'b1) busy_bad++;
            tick();
            cyc++;
        end
        chk({tag, " done_seen"}, 64'(done), 64'(1));
        if (done === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " quotient"},  64'(quotient),  64'(e.q));
            chk({tag, " remainder"}, 64'(remainder), 64'(e.r));
            chk({tag, " div_zero"},  64'(div_zero),  64'(e.dz));
            chk({tag, " done_cycle"}, 64'(cyc), 64'(e.cyc));
            chk({tag, " busy_in_done"}, 64'(busy), 64'(1));
        end
        chk({tag, " busy_while_running"}, 64'(busy_bad), 64'(0));
        tick();
        cyc++;
        chk({tag, " done_single_pulse"}, 64'(done), 64'(0));
        chk({tag, " idle_after"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int seen;
        reset = 1'b1; start = 1'b0; is_signed = 1'b0; abort = 1'b0;
        dividend = '0; divisor = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst quotient", 64'(quotient), 64'(0));
        chk("rst remainder", 64'(remainder), 64'(0));
        chk("rst div_zero", 64'(div_zero), 64'(0));

        issue(32'd100, 32'd7, 1'b0, 32'h0000000E, 32'h00000002, 1'b0, 35, 1);
        chk("divu100/7 busy_c1", 64'(busy), 64'(1));
        wait_done("divu100/7");

        issue(32'hFFFFFFF9, 32'h2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 35, 1);
        wait_done("div-7/2");
        issue(32'hFFFFFFF9, 32'h2, 1'b0, 32'h7FFFFFFC, 32'h00000001, 1'b0, 35, 1);
        wait_done("divu-7/2");

        issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0, 1'b0, 35, 1);
        wait_done("div_ovf");

        issue(32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h5, 1'b1, 2, 1);
        wait_done("divu5/0");

        // New start clears div_zero immediately
        issue(32'd100, 32'd7, 1'b0, 32'h0000000E, 32'h00000002, 1'b0, 35, 1);
        chk("dz_clear", 64'(div_zero), 64'(0));
        wait_done("divu100/7b");

        // Abort in cycle 10 of 9/3
        issue(32'd9, 32'd3, 1'b0, '0, '0, 1'b0, 0, 0);
        while (cyc < 10) begin tick(); cyc++; end
        abort = 1'b1;
        tick(); cyc++;
        abort = 1'b0;
        chk("abort busy_c11", 64'(busy), 64'(0));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) seen++;
            tick();
        end
        chk("abort no_done", 64'(seen), 64'(0));
        chk("abort quotient", 64'(quotient), 64'(32'h0E));
        chk("abort remainder", 64'(remainder), 64'(32'h02));

        // start in cycle 5 of a running op is ignored
        issue(32'd20, 32'd6, 1'b0, 32'd3, 32'd2, 1'b0, 35, 1);
        while (cyc < 5) begin tick(); cyc++; end
        dividend = 32'd1; divisor = 32'd1; is_signed = 1'b1; start = 1'b1;
        tick(); cyc++;
        start = 1'b0;
        wait_done("busy_start");

        issue(32'd3, 32'd10, 1'b0, 32'd0, 32'd3, 1'b0, EARLY_CYC, 1);
        wait_done("divu3/10");

        // Reset in cycle 20 of a running op
        issue(32'd100, 32'd7, 1'b0, '0, '0, 1'b0, 0, 0);
        while (cyc < 20) begin tick(); cyc++; end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst busy", 64'(busy), 64'(0));
        chk("midrst done", 64'(done), 64'(0));
        chk("midrst quotient", 64'(quotient), 64'(0));
        chk("midrst remainder", 64'(remainder), 64'(0));
        chk("midrst div_zero", 64'(div_zero), 64'(0));
        chk("sb empty", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
